// File: rtl/sigmoid_div.sv
// Restoring fixed-point divider: y = floor(2^(2*FRAC_BITS) / (ONE + max(exp_i, 0))).
// It produces one quotient bit per clock and uses valid/ready handshakes on the input and output sides.
module sigmoid_div #(
    parameter int DATA_WIDTH = 32,
    parameter int INT_BITS   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] exp_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] y_o,
    output logic                  busy_o
);

    localparam int FRAC_BITS = DATA_WIDTH - INT_BITS;
    localparam int QBITS     = FRAC_BITS + 1;
    localparam int CNT_W     = $clog2(FRAC_BITS + 1);

    localparam logic [DATA_WIDTH:0]   ONE_EXT = {{INT_BITS{1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE     = ONE_EXT[DATA_WIDTH-1:0];
    localparam logic [CNT_W-1:0]      LAST    = CNT_W'(FRAC_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] divisor_reg;
    logic [DATA_WIDTH:0]   rem_reg;
    logic [FRAC_BITS-1:0]  quot_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DATA_WIDTH-1:0] y_reg;

    logic                  accept;
    logic                  last_step;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH:0]   shifted;
    logic                  q_bit;
    logic [DATA_WIDTH:0]   rem_step;
    logic [DATA_WIDTH-1:0] y_next;

    assign accept    = in_valid_i && (state_reg == IDLE);
    assign last_step = (cnt_reg == LAST);
    assign operand   = exp_i[DATA_WIDTH-1] ? '0 : exp_i;

    // Numerator bits above the quotient range always yield zero quotient bits,
    // so they collapse into a remainder of ONE on the first step; every later
    // numerator bit is zero.
    assign shifted  = (cnt_reg == '0) ? ONE_EXT : (rem_reg << 1);
    assign q_bit    = (shifted >= {1'b0, divisor_reg});
    assign rem_step = q_bit ? (shifted - {1'b0, divisor_reg}) : shifted;
    assign y_next   = {{(DATA_WIDTH-QBITS){1'b0}}, quot_reg, q_bit};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid_i) state_next = DIV;
            DIV:     if (last_step) state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divisor_reg <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            cnt_reg     <= '0;
            y_reg       <= '0;
        end else if (accept) begin
            divisor_reg <= ONE + operand;
            rem_reg     <= '0;
            quot_reg    <= '0;
            cnt_reg     <= '0;
        end else if (state_reg == DIV) begin
            rem_reg  <= rem_step;
            quot_reg <= {quot_reg[FRAC_BITS-2:0], q_bit};
            cnt_reg  <= cnt_reg + CNT_W'(1);
            if (last_step) begin
                y_reg <= y_next;
            end
        end
    end

    assign in_ready_o  = (state_reg == IDLE);
    assign busy_o      = (state_reg == DIV);
    assign out_valid_o = (state_reg == DONE);
    assign y_o         = y_reg;

endmodule

// File: tb/tb_sigmoid_div.sv
// Directed bench for sigmoid_div: latency, values, backpressure, mid-division reset, streaming.
`timescale 1ns/1ps
module tb_sigmoid_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] exp_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        busy;

    int errors = 0;
    int checks = 0;

    sigmoid_div #(.DATA_WIDTH(32), .INT_BITS(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .exp_i       (exp_val),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .y_o         (y),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand (block assumed idle) and waits for out_valid; no checking here.
    task automatic run_op(input logic [31:0] val, output int lat, output int busy_cnt);
        @(negedge clk);
        exp_val  = val;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (y !== 32'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", y); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: in_ready=%b out_valid=%b busy=%b y=%0d", in_ready, out_valid, busy, y);
    endtask

    task automatic test_one();
        int lat, bc;
        run_op(32'd65536, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL one_latency got=%0d exp=17", lat); end
        checks++; if (bc !== 17) begin errors++; $display("FAIL one_busy_cycles got=%0d exp=17", bc); end
        checks++; if (y !== 32'd32768) begin errors++; $display("FAIL one_y got=%0d exp=32768", y); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL one_done_flags got busy=%b in_ready=%b exp 0 0", busy, in_ready); end
        $display("exp=65536 y=%0d latency=%0d busy_cycles=%0d", y, lat, bc);
        take_result();
    endtask

    task automatic test_zero_negative();
        int lat, bc;
        run_op(32'd0, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency got=%0d exp=17", lat); end
        checks++; if (y !== 32'd65536) begin errors++; $display("FAIL zero_y got=%0d exp=65536", y); end
        $display("exp=0 y=%0d latency=%0d", y, lat);
        take_result();
        run_op(-32'sd5, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL neg_latency got=%0d exp=17", lat); end
        checks++; if (y !== 32'd65536) begin errors++; $display("FAIL neg_y got=%0d exp=65536", y); end
        $display("exp=-5 y=%0d latency=%0d", y, lat);
        take_result();
    endtask

    task automatic test_values();
        int lat, bc;
        run_op(32'd24109, lat, bc);
        checks++; if (y !== 32'd47910) begin errors++; $display("FAIL e_minus1_y got=%0d exp=47910", y); end
        $display("exp=24109 y=%0d latency=%0d", y, lat);
        take_result();
        run_op(32'h7FFF_FFFF, lat, bc);
        checks++; if (y !== 32'd1) begin errors++; $display("FAIL max_y got=%0d exp=1", y); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL max_latency got=%0d exp=17", lat); end
        $display("exp=7fffffff y=%0d latency=%0d", y, lat);
        take_result();
    endtask

    task automatic test_backpressure();
        int lat, bc;
        run_op(32'd24109, lat, bc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            exp_val  = 32'd0;
            checks++; if (y !== 32'd47910 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_y cycle=%0d got=%0d valid=%b exp=47910 valid=1", i, y, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle=%0d got=%b exp=0", i, in_ready); end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL handshake_cycle_in_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL after_handshake got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL competing_input_ignored got busy=%b in_ready=%b exp 0 1", busy, in_ready); end
        $display("backpressure: y=%0d held 10 cycles, in_ready=%b after handshake", y, in_ready);
    endtask

    task automatic test_mid_reset();
        int lat, bc, seen;
        @(negedge clk);
        exp_val  = 32'd131072;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flags got in_ready=%b busy=%b out_valid=%b exp 1 0 0", in_ready, busy, out_valid); end
        checks++; if (y !== 32'd0) begin errors++; $display("FAIL midreset_y got=%0d exp=0", y); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_output got=%0d exp=0", seen); end
        run_op(32'd65536, lat, bc);
        checks++; if (y !== 32'd32768) begin errors++; $display("FAIL post_reset_y got=%0d exp=32768", y); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL post_reset_latency got=%0d exp=17", lat); end
        $display("mid reset: aborted, fresh y=%0d latency=%0d", y, lat);
        take_result();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [4];
        logic [31:0] exps [4];
        int acc_cyc [4];
        int idx, res, cyc;
        ops[0] = 32'd65536;  exps[0] = 32'd32768;
        ops[1] = 32'd24109;  exps[1] = 32'd47910;
        ops[2] = 32'd0;      exps[2] = 32'd65536;
        ops[3] = 32'd131072; exps[3] = 32'd21845;
        idx = 0; res = 0; cyc = 0;
        out_ready = 1'b1;
        while (res < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid = (idx < 4);
            exp_val  = (idx < 4) ? ops[idx] : 32'd0;
            if (out_valid) begin
                checks++; if (y !== exps[res]) begin errors++; $display("FAIL stream_y idx=%0d got=%0d exp=%0d", res, y, exps[res]); end
                $display("stream result %0d: y=%0d", res, y);
                res++;
            end
            if (in_ready && in_valid) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (res !== 4 || idx !== 4) begin errors++; $display("FAIL stream_count got results=%0d accepts=%0d exp 4 4", res, idx); end
        if (idx == 4) begin
            for (int k = 1; k < 4; k++) begin
                checks++; if (acc_cyc[k] - acc_cyc[k-1] !== 19) begin errors++; $display("FAIL stream_spacing gap=%0d got=%0d exp=19", k, acc_cyc[k] - acc_cyc[k-1]); end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_val   = 32'd0;
        test_reset();
        test_one();
        test_zero_negative();
        test_values();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
